apb_servo_array: RTL and testbench

//  APB3 slave driving N_CH servo PWM outputs from one shared period counter, with optional per-period slew limiting.

---
 rtl/servo_pkg.sv | 45 ++++
 rtl/sw_debounce.sv | 42 ++++
 rtl/apb_servo_array.sv | 154 +++++++++++++++
 tb/tb_apb_servo_array.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared register map, control layout and reset defaults for the APB servo array.
package servo_pkg;

  localparam int unsigned APB_W    = 32;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned TGT_BASE = 16;
  localparam int unsigned MIN_PER  = 2;

  localparam logic [IDX_W-1:0] REG_CTRL   = 5'h00;
  localparam logic [IDX_W-1:0] REG_PERIOD = 5'h01;
  localparam logic [IDX_W-1:0] REG_STEP   = 5'h02;
  localparam logic [IDX_W-1:0] REG_SW     = 5'h03;
  localparam logic [IDX_W-1:0] REG_PEND   = 5'h04;
  localparam logic [IDX_W-1:0] REG_MASK   = 5'h05;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_RAMP = 1;

  localparam int unsigned DEF_PER   = 2000000;
  localparam int unsigned DEF_PULSE = 90000;

  typedef struct packed {
    logic ramp_en;
    logic en;
  } ctrl_t;

  // Move cur toward tgt by at most step; step of 0 or ramp disabled jumps straight to tgt.
  function automatic logic [APB_W-1:0] ramp_next(input logic [APB_W-1:0] cur,
                                                 input logic [APB_W-1:0] tgt,
                                                 input logic [APB_W-1:0] step,
                                                 input logic             ramp_en);
    logic [APB_W-1:0] diff;
    ramp_next = tgt;
    if (ramp_en && (step != '0)) begin
      if (tgt > cur) begin
        diff      = tgt - cur;
        ramp_next = (diff > step) ? (cur + step) : tgt;
      end else begin
        diff      = cur - tgt;
        ramp_next = (diff > step) ? (cur - step) : tgt;
      end
    end
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Switch conditioner: 2-FF synchroniser, stability counter and rising-edge pulse of the debounced state.
module sw_debounce #(
  parameter int unsigned DB_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic state,
  output logic rise_c
);

  logic            sync1;
  logic            sync2;
  logic            state_d;
  logic [DB_W-1:0] cnt_q;

  // Raw input is active-low; the synchronised value is 1 while pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      state   <= 1'b0;
      state_d <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1   <= ~sw_raw;
      sync2   <= sync1;
      state_d <= state;
      if (sync2 == state) begin
        cnt_q <= '0;
      end else if (&cnt_q) begin
        state <= ~state;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + DB_W'(1);
      end
    end
  end

  assign rise_c = state & ~state_d;

endmodule

// File: rtl/apb_servo_array.sv
// APB3 slave: N_CH servo PWM channels on one shared period counter with optional slew limiting,
// plus N_SW debounced switches raising maskable W1C interrupt-pending bits on FABINT.
module apb_servo_array
  import servo_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned N_SW      = 2,
  parameter int unsigned CNT_W     = 24,
  parameter int unsigned DB_W      = 16,
  parameter int unsigned RST_PER   = DEF_PER,
  parameter int unsigned RST_PULSE = DEF_PULSE
) (
  input  logic             PCLK,
  input  logic             PRESERN,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [31:0]      PADDR,
  input  logic [31:0]      PWDATA,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  input  logic [N_SW-1:0]  SW_IN,
  output logic [N_CH-1:0]  pwm,
  output logic             FABINT
);

  logic [IDX_W-1:0] idx;
  logic             wr_en;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] step_q;
  logic [N_SW-1:0]  mask_q;
  logic [N_SW-1:0]  pend_q;
  logic [N_SW-1:0]  pend_clr_c;
  logic [N_SW-1:0]  sw_state;
  logic [N_SW-1:0]  sw_rise;
  logic [CNT_W-1:0] tgt_q    [N_CH];
  logic [CNT_W-1:0] cur_q    [N_CH];
  logic [CNT_W-1:0] cur_next [N_CH];
  logic [N_CH-1:0]  pwm_next;
  logic [CNT_W-1:0] per_eff;
  logic [CNT_W-1:0] per_act_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wrap;
  logic             shadow_upd;
  logic             unused;

  assign idx     = PADDR[6:2];
  assign wr_en   = PSEL & PENABLE & PWRITE;
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign unused  = ^{PADDR[31:7], PADDR[1:0], PWDATA};

  // Software-writable configuration registers.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      ctrl_q   <= '{ramp_en: 1'b0, en: 1'b1};
      period_q <= CNT_W'(RST_PER);
      step_q   <= '0;
      mask_q   <= '0;
      for (int i = 0; i < N_CH; i++) tgt_q[i] <= CNT_W'(RST_PULSE);
    end else if (wr_en) begin
      case (idx)
        REG_CTRL:   ctrl_q   <= '{ramp_en: PWDATA[CTRL_RAMP], en: PWDATA[CTRL_EN]};
        REG_PERIOD: period_q <= PWDATA[CNT_W-1:0];
        REG_STEP:   step_q   <= PWDATA[CNT_W-1:0];
        REG_MASK:   mask_q   <= PWDATA[N_SW-1:0];
        default:    ;
      endcase
      for (int i = 0; i < N_CH; i++) begin
        if (idx == IDX_W'(TGT_BASE + i)) tgt_q[i] <= PWDATA[CNT_W-1:0];
      end
    end
  end

  // Pending bits: a new edge wins over a simultaneous write-1-to-clear.
  assign pend_clr_c = (wr_en && (idx == REG_PEND)) ? PWDATA[N_SW-1:0] : '0;

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      pend_q <= '0;
      FABINT <= 1'b0;
    end else begin
      pend_q <= (pend_q & ~pend_clr_c) | sw_rise;
      FABINT <= |(pend_q & mask_q);
    end
  end

  for (genvar gj = 0; gj < N_SW; gj++) begin : g_sw
    sw_debounce #(.DB_W(DB_W)) u_db (
      .clk    (PCLK),
      .rst_n  (PRESERN),
      .sw_raw (SW_IN[gj]),
      .state  (sw_state[gj]),
      .rise_c (sw_rise[gj])
    );
  end

  // Shared period counter; period and pulse widths are only reloaded at wrap or while disabled.
  assign per_eff    = (period_q < CNT_W'(MIN_PER)) ? CNT_W'(MIN_PER) : period_q;
  assign wrap       = (cnt_q == (per_act_q - CNT_W'(1)));
  assign shadow_upd = wrap | ~ctrl_q.en;

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      cnt_q     <= '0;
      per_act_q <= CNT_W'(RST_PER);
    end else begin
      if (!ctrl_q.en || wrap) cnt_q <= '0;
      else                    cnt_q <= cnt_q + CNT_W'(1);
      if (shadow_upd) per_act_q <= per_eff;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign cur_next[gi] = !ctrl_q.en ? tgt_q[gi] :
                          CNT_W'(ramp_next(APB_W'(cur_q[gi]), APB_W'(tgt_q[gi]),
                                           APB_W'(step_q), ctrl_q.ramp_en));
    assign pwm_next[gi] = ctrl_q.en & (cnt_q < cur_q[gi]);
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      pwm <= '0;
      for (int i = 0; i < N_CH; i++) cur_q[i] <= CNT_W'(RST_PULSE);
    end else begin
      pwm <= pwm_next;
      if (shadow_upd) begin
        for (int i = 0; i < N_CH; i++) cur_q[i] <= cur_next[i];
      end
    end
  end

  // Read mux: targets read back as written, not the slewing current value.
  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (idx)
        REG_CTRL:   PRDATA = 32'(ctrl_q);
        REG_PERIOD: PRDATA = 32'(period_q);
        REG_STEP:   PRDATA = 32'(step_q);
        REG_SW:     PRDATA = 32'(sw_state);
        REG_PEND:   PRDATA = 32'(pend_q);
        REG_MASK:   PRDATA = 32'(mask_q);
        default:    ;
      endcase
      for (int i = 0; i < N_CH; i++) begin
        if (idx == IDX_W'(TGT_BASE + i)) PRDATA = 32'(tgt_q[i]);
      end
    end
  end

endmodule

// File: tb/tb_apb_servo_array.sv
// Scoreboard bench for apb_servo_array: reads and PWM pulse widths are predicted by a register-level model.
module tb_apb_servo_array;

  localparam int unsigned N_CH      = 4;
  localparam int unsigned N_SW      = 2;
  localparam int unsigned CNT_W     = 24;
  localparam int unsigned DB_W      = 4;
  localparam int unsigned RST_PER   = 200;
  localparam int unsigned RST_PULSE = 90;

  logic            PCLK = 1'b0;
  logic            PRESERN;
  logic            PSEL;
  logic            PENABLE;
  logic            PWRITE;
  logic [31:0]     PADDR;
  logic [31:0]     PWDATA;
  logic [31:0]     PRDATA;
  logic            PREADY;
  logic            PSLVERR;
  logic [N_SW-1:0] SW_IN;
  logic [N_CH-1:0] pwm;
  logic            FABINT;

  apb_servo_array #(
    .N_CH(N_CH), .N_SW(N_SW), .CNT_W(CNT_W), .DB_W(DB_W),
    .RST_PER(RST_PER), .RST_PULSE(RST_PULSE)
  ) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .SW_IN(SW_IN), .pwm(pwm), .FABINT(FABINT)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_tgt [N_CH];
  logic [31:0] m_cur [N_CH];
  logic [31:0] m_per, m_step, m_mask, m_pend, m_sw;
  logic        m_en, m_ramp;

  // Scoreboard queues
  logic [31:0] rd_q [$];
  string       rd_n [$];
  logic [31:0] pulse_q [N_CH][$];
  logic [31:0] run_len [N_CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] step_toward(input logic [31:0] c, input logic [31:0] t,
                                              input logic [31:0] s, input logic r);
    if (!r || s == 0) return t;
    if (t > c) return (t - c > s) ? c + s : t;
    return (c - t > s) ? c - s : t;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int k;
    k = int'(a[6:2]);
    case (k)
      0: return {30'd0, m_ramp, m_en};
      1: return m_per;
      2: return m_step;
      3: return m_sw;
      4: return m_pend;
      5: return m_mask;
      default: begin
        if (k >= 16 && k < 16 + int'(N_CH)) return m_tgt[k-16];
        return 32'd0;
      end
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_tgt[i] = RST_PULSE;
      m_cur[i] = RST_PULSE;
    end
    m_per = RST_PER; m_step = 0; m_mask = 0; m_pend = 0; m_sw = 0;
    m_en = 1'b1; m_ramp = 1'b0;
  endtask

  // Called on a negedge; the write strobe lands on the second following posedge.
  task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
    int k;
    k = int'(a[6:2]);
    case (k)
      0: begin m_en = d[0]; m_ramp = d[1]; end
      1: m_per  = {8'd0, d[23:0]};
      2: m_step = {8'd0, d[23:0]};
      4: m_pend = m_pend & ~{30'd0, d[1:0]};
      5: m_mask = {30'd0, d[1:0]};
      default: if (k >= 16 && k < 16 + int'(N_CH)) m_tgt[k-16] = {8'd0, d[23:0]};
    endcase
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic reg_read(input logic [31:0] a, input string name);
    rd_q.push_back(model_read(a));
    rd_n.push_back(name);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_rise(input int ch, output int cyc);
    logic prev;
    prev = pwm[ch];
    cyc  = 0;
    while (cyc < 3000) begin
      @(negedge PCLK);
      cyc++;
      if (pwm[ch] && !prev) return;
      prev = pwm[ch];
    end
    checks++; errors++;
    $display("FAIL rise_timeout_ch%0d: got no rising edge, expected one within 3000 cycles", ch);
  endtask

  task automatic wait_drain(input int ch);
    int k;
    k = 0;
    while (pulse_q[ch].size() != 0 && k < 6000) begin
      @(negedge PCLK);
      k++;
    end
    check($sformatf("drain_ch%0d", ch), 32'(pulse_q[ch].size()), 32'd0);
  endtask

  // Expected widths: the pulse in progress, then one per period until the target is reached.
  task automatic push_seq(input int ch, input logic [31:0] tgt);
    logic [31:0] c;
    c = m_cur[ch];
    pulse_q[ch].push_back(c);
    do begin
      c = step_toward(c, tgt, m_step, m_ramp);
      pulse_q[ch].push_back(c);
    end while (c != tgt);
    m_cur[ch] = tgt;
  endtask

  // Read monitor: samples mid-cycle during the access phase.
  always @(negedge PCLK) begin
    #1;
    if (PSEL && PENABLE && !PWRITE) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got %0d, expected no read", PRDATA);
      end else begin
        check(rd_n.pop_front(), PRDATA, rd_q.pop_front());
      end
    end
  end

  // Pulse monitor: compares each completed high run against the next expectation, if any.
  always @(negedge PCLK) begin
    for (int c = 0; c < N_CH; c++) begin
      if (pwm[c]) begin
        run_len[c] = run_len[c] + 32'd1;
      end else begin
        if (run_len[c] != 0 && pulse_q[c].size() != 0)
          check($sformatf("pulse_ch%0d", c), run_len[c], pulse_q[c].pop_front());
        run_len[c] = 32'd0;
      end
    end
  end

  initial begin
    int cyc;
    int hi;
    int ch;
    logic [31:0] t, s, a;
    logic r;

    for (int i = 0; i < N_CH; i++) run_len[i] = 32'd0;
    model_reset();
    PRESERN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; SW_IN = '1;
    repeat (3) @(negedge PCLK);
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_fabint", 32'(FABINT), 32'd0);
    PRESERN = 1'b1;

    reg_read(32'h04, "rd_period_rst");
    reg_read(32'h40, "rd_tgt0_rst");
    reg_read(32'h00, "rd_ctrl_rst");
    reg_read(32'h08, "rd_step_rst");
    reg_read(32'h0C, "rd_sw_rst");
    reg_read(32'h10, "rd_pend_rst");
    reg_read(32'h14, "rd_mask_rst");
    reg_read(32'h18, "rd_unmapped");

    // Default pulse width and period
    wait_rise(0, cyc);
    pulse_q[0].push_back(32'(RST_PULSE));
    wait_rise(0, cyc);
    check("period_ch0", 32'(cyc), 32'(RST_PER));
    wait_drain(0);

    // Target change mid-period applies from the next period
    wait_rise(1, cyc);
    push_seq(1, 32'd150);
    reg_write(32'h44, 32'd150);
    reg_read(32'h44, "rd_tgt1");
    wait_drain(1);

    // Slew-limited ramp 90 -> 120 in steps of 10
    reg_write(32'h00, 32'd3);
    reg_write(32'h08, 32'd10);
    wait_rise(0, cyc);
    push_seq(0, 32'd120);
    pulse_q[0].push_back(32'd120);
    reg_write(32'h40, 32'd120);
    wait_drain(0);

    // Pulse >= period is constant high, zero is constant low
    reg_write(32'h00, 32'd1);
    reg_write(32'h04, 32'd100);
    reg_write(32'h48, 32'd150);
    repeat (450) @(negedge PCLK);
    hi = 0;
    repeat (250) begin @(negedge PCLK); hi += int'(pwm[2]); end
    check("ch2_const_high", 32'(hi), 32'd250);
    wait_rise(3, cyc);
    wait_rise(3, cyc);
    check("period_ch3", 32'(cyc), 32'd100);
    reg_write(32'h48, 32'd0);
    repeat (250) @(negedge PCLK);
    hi = 0;
    repeat (250) begin @(negedge PCLK); hi += int'(pwm[2]); end
    check("ch2_const_low", 32'(hi), 32'd0);

    // PERIOD below 2 behaves as 2
    reg_write(32'h4C, 32'd1);
    reg_write(32'h04, 32'd0);
    repeat (300) @(negedge PCLK);
    wait_rise(3, cyc);
    pulse_q[3].push_back(32'd1);
    wait_rise(3, cyc);
    check("period_min", 32'(cyc), 32'd2);
    wait_drain(3);
    reg_read(32'h04, "rd_period_zero");

    reg_write(32'h40, 32'd50);
    reg_write(32'h44, 32'd60);
    reg_write(32'h4C, 32'd70);
    reg_write(32'h04, 32'd100);
    repeat (400) @(negedge PCLK);
    for (int i = 0; i < N_CH; i++) m_cur[i] = m_tgt[i];

    // Randomised targets, ramp settings and readback
    for (int it = 0; it < 10; it++) begin
      ch = int'($urandom_range(0, 2));
      if (ch == 2) ch = 3;
      t = $urandom_range(1, 99);
      r = 1'($urandom_range(0, 1));
      s = $urandom_range(5, 40);
      reg_write(32'h00, {30'd0, r, 1'b1});
      reg_write(32'h08, s);
      wait_rise(ch, cyc);
      push_seq(ch, t);
      reg_write(32'h40 + 32'(4 * ch), t);
      wait_drain(ch);
      case ($urandom_range(0, 8))
        0: a = 32'h00;
        1: a = 32'h04;
        2: a = 32'h08;
        3: a = 32'h0C;
        4: a = 32'h10;
        5: a = 32'h14;
        6: a = 32'h40 + 32'(4 * $urandom_range(0, 3));
        7: a = 32'h50;
        default: a = 32'h1C;
      endcase
      reg_read(a, $sformatf("rd_rand_%0h", a));
    end

    // Bounce shorter than the debounce window is ignored
    repeat (4) begin
      SW_IN[0] = 1'b0;
      repeat (8) @(negedge PCLK);
      SW_IN[0] = 1'b1;
      repeat (4) @(negedge PCLK);
    end
    repeat (20) @(negedge PCLK);
    reg_read(32'h0C, "rd_sw_bounce");
    reg_read(32'h10, "rd_pend_bounce");

    // Stable press sets SW and PEND; FABINT only once masked in
    SW_IN[0] = 1'b0;
    repeat (30) @(negedge PCLK);
    m_sw = 32'd1; m_pend = 32'd1;
    reg_read(32'h0C, "rd_sw_press");
    reg_read(32'h10, "rd_pend_press");
    check("fabint_masked", 32'(FABINT), 32'd0);
    reg_write(32'h14, 32'd1);
    check("fabint_lag", 32'(FABINT), 32'd0);
    repeat (2) @(negedge PCLK);
    check("fabint_unmasked", 32'(FABINT), 32'd1);
    reg_write(32'h10, 32'd1);
    repeat (2) @(negedge PCLK);
    reg_read(32'h10, "rd_pend_w1c");
    check("fabint_cleared", 32'(FABINT), 32'd0);

    SW_IN[0] = 1'b1;
    repeat (30) @(negedge PCLK);
    m_sw = 32'd0;
    reg_read(32'h0C, "rd_sw_release");
    reg_read(32'h10, "rd_pend_release");

    // W1C in the same cycle as a new edge: set wins
    SW_IN[0] = 1'b0;
    repeat (17) @(negedge PCLK);
    reg_write(32'h10, 32'd1);
    m_pend = 32'd1;
    repeat (20) @(negedge PCLK);
    reg_read(32'h10, "rd_pend_set_wins");
    check("fabint_set_wins", 32'(FABINT), 32'd1);
    SW_IN[0] = 1'b1;
    repeat (30) @(negedge PCLK);

    // Asynchronous reset in the middle of a high phase
    reg_write(32'h00, 32'd1);
    reg_write(32'h40, 32'd60);
    repeat (300) @(negedge PCLK);
    wait_rise(0, cyc);
    repeat (5) @(negedge PCLK);
    check("pre_reset_high", 32'(pwm[0]), 32'd1);
    #2 PRESERN = 1'b0;
    #1;
    check("async_rst_pwm", 32'(pwm), 32'd0);
    check("async_rst_fabint", 32'(FABINT), 32'd0);
    @(negedge PCLK);
    PRESERN = 1'b1;
    model_reset();
    reg_read(32'h04, "rd_period_rst2");
    reg_read(32'h40, "rd_tgt0_rst2");
    reg_read(32'h10, "rd_pend_rst2");
    wait_rise(0, cyc);
    pulse_q[0].push_back(32'(RST_PULSE));
    wait_rise(0, cyc);
    check("period_ch0_rst2", 32'(cyc), 32'(RST_PER));
    wait_drain(0);

    repeat (5) @(negedge PCLK);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
    for (int i = 0; i < N_CH; i++)
      check($sformatf("pulse_q_empty_ch%0d", i), 32'(pulse_q[i].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
